// File: rtl/ram_pkg.sv
// Shared definitions for the word-addressed RAM bank: state encoding and default geometry.
// No logic lives here, so it adds no latency.
// No flow control; consumers import what they need.
package ram_pkg;

  // Default geometry. Instantiations normally override these.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;

  // INIT: the array is being swept to zero. READY: requests are accepted.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/ram_bank_core.sv
// Storage array with per-byte write enables and a registered read port.
// Read latency 1 cycle: data for a read strobed at edge N is visible after edge N.
// No backpressure; the caller guarantees at most one write and one read per cycle.
module ram_bank_core
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [BE_WIDTH-1:0]   i_wbe,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane write: only lanes with their enable set are touched. The array is
  // deliberately not reset; the bank's zero sweep defines its contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read; the data register only moves on a read so it holds between responses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_bank.sv
// Single-port RAM bank with zero-sweep initialisation, byte-enable writes and read responses.
// Read latency 1 cycle, or 2 when RAM_OUTREG_EN is defined (adds an output register).
// req_ready is low for the whole sweep (DEPTH cycles); responses have no backpressure.
module ram_bank
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  input  logic                  clear,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  w_sweep;

  logic                  w_accept;
  logic                  w_rd;
  logic                  w_wr_req;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_dat;
  logic [BE_WIDTH-1:0]   w_mem_be;
  logic [DATA_WIDTH-1:0] w_core_rdata;

  logic                  r_rd_vld;

  // Ready is a pure function of state so the requester never sees a combinational path.
  assign req_ready = (r_state == READY);
  assign init_done = (r_state == READY);

  assign w_accept = req_valid && req_ready;
  assign w_rd     = w_accept && !req_write;
  // A write with no byte enables is accepted but changes nothing.
  assign w_wr_req = w_accept && req_write && (req_be != '0);

  // Next state: sweep one word per cycle in INIT; clear only restarts the sweep from READY.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sweep     = 1'b0;
    case (r_state)
      INIT: begin
        w_sweep   = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        if (clear) begin
          w_state_nxt = INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and sweep counter register; reset always restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Write port mux: the sweep owns the array in INIT, requests own it in READY,
  // so the two sources are never active together.
  always_comb begin
    w_mem_we   = reset_n && (w_sweep || w_wr_req);
    w_mem_addr = req_addr;
    w_mem_dat  = req_wdata;
    w_mem_be   = req_be;
    if (w_sweep) begin
      w_mem_addr = r_cnt;
      w_mem_dat  = '0;
      w_mem_be   = '1;
    end
  end

  ram_bank_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_addr),
    .i_wdata (w_mem_dat),
    .i_wbe   (w_mem_be),
    .i_re    (w_rd),
    .i_raddr (req_addr),
    .o_rdata (w_core_rdata)
  );

  // Response valid tracks the core read register; clear does not touch it, so reads
  // in flight when a sweep starts still complete, while reset drops them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_rd;
    end
  end

`ifdef RAM_OUTREG_EN
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_dat;

  // Output stage: retime the array read; data only moves with a response so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      r_out_vld <= r_rd_vld;
      if (r_rd_vld) begin
        r_out_dat <= w_core_rdata;
      end
    end
  end

  assign rsp_valid = r_out_vld;
  assign rsp_rdata = r_out_dat;
`else
  assign rsp_valid = r_rd_vld;
  assign rsp_rdata = w_core_rdata;
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Bench for ram_bank with DATA_WIDTH=32, ADDR_WIDTH=4, checked against a plain array model.
// Read latency follows the RAM_OUTREG_EN build (1 or 2 cycles).
// Responses are captured every cycle and compared with the model's expected timing and data.
module tb_ram_bank;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  typedef struct {
    int            cyc;
    logic [DW-1:0] dat;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          clear;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;

  int            nvec = 0;
  int            nerr = 0;
  int            cyc  = 0;
  logic [DW-1:0] model_mem [DEPTH];
  rsp_t          obs_q [$];
  rsp_t          exp_q [$];

  ram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .clear     (clear),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with a response is logged together with the cycle it appeared in.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      obs_q.push_back('{cyc, rsp_rdata});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic idle;
    req_valid = 1'b0;
    req_write = 1'b0;
    clear     = 1'b0;
  endtask

  // Drives one write for a cycle and applies it to the model byte by byte.
  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    for (int b = 0; b < BW; b++) begin
      if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    tick();
  endtask

  // Drives one read for a cycle; the expected response is due L edges after acceptance.
  task automatic issue_read(input logic [AW-1:0] a);
    exp_q.push_back('{cyc + L, model_mem[a]});
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    req_wdata = $urandom;
    req_be    = BW'($urandom);
    tick();
  endtask

  task automatic test_reset;
    idle();
    reset_n = 1'b0;
    repeat (3) tick();
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    nvec++; if (rsp_rdata !== '0) begin nerr++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    nvec++; if (init_done !== 1'b0) begin nerr++; $display("FAIL reset_init_done got %b want 0", init_done); end
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    reset_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      nvec++;
      if (req_ready !== (i == DEPTH)) begin
        nerr++; $display("FAIL init_sweep_ready cycle %0d got %b want %b", i, req_ready, i == DEPTH);
      end
    end
    nvec++; if (init_done !== 1'b1) begin nerr++; $display("FAIL init_done got %b want 1", init_done); end
    model_zero();
    obs_q.delete();
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) issue_read(AW'(a));
    idle();
    repeat (L + 2) tick();
    nvec++; if (obs_q.size() !== exp_q.size()) begin nerr++; $display("FAIL zero_readback count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].dat !== exp_q[i].dat) begin
        nerr++; $display("FAIL zero_readback[%0d] got %h@%0d want %h@%0d", i, obs_q[i].dat, obs_q[i].cyc, exp_q[i].dat, exp_q[i].cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_byte_enable;
    issue_write(4'd3, 32'hDEADBEEF, 4'hF);
    issue_write(4'd3, 32'h11223344, 4'h5);
    issue_read(4'd3);
    idle();
    repeat (L + 2) tick();
    nvec++; if (model_mem[3] !== 32'hDE22BE44) begin nerr++; $display("FAIL be_model got %h want DE22BE44", model_mem[3]); end
    nvec++; if (obs_q.size() !== 1) begin nerr++; $display("FAIL be_count got %0d want 1", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].dat !== 32'hDE22BE44) begin
        nerr++; $display("FAIL be_merge got %h@%0d want DE22BE44@%0d", obs_q[i].dat, obs_q[i].cyc, exp_q[i].cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_be_zero;
    issue_write(4'd2, 32'h12345678, 4'hF);
    issue_write(4'd2, 32'hCAFEF00D, 4'h0);
    idle();
    tick();
    nvec++; if (obs_q.size() !== 0) begin nerr++; $display("FAIL be0_no_rsp got %0d responses want 0", obs_q.size()); end
    issue_read(4'd2);
    idle();
    repeat (L + 2) tick();
    nvec++; if (obs_q.size() !== 1) begin nerr++; $display("FAIL be0_count got %0d want 1", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].dat !== 32'h12345678) begin
        nerr++; $display("FAIL be0_data got %h@%0d want 12345678@%0d", obs_q[i].dat, obs_q[i].cyc, exp_q[i].cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    issue_write(4'd0, 32'hA, 4'hF);
    issue_write(4'd1, 32'hB, 4'hF);
    issue_write(4'd2, 32'hC, 4'hF);
    issue_read(4'd0);
    issue_read(4'd1);
    issue_read(4'd2);
    idle();
    repeat (L + 2) tick();
    nvec++; if (obs_q.size() !== 3) begin nerr++; $display("FAIL b2b_count got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[0].cyc + i || obs_q[i].dat !== 32'(10 + i)) begin
        nerr++; $display("FAIL b2b[%0d] got %h@%0d want %h@%0d", i, obs_q[i].dat, obs_q[i].cyc, 10 + i, exp_q[0].cyc + i);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: begin idle(); tick(); end
        1: issue_write(AW'($urandom), $urandom, BW'($urandom));
        default: issue_read(AW'($urandom));
      endcase
    end
    idle();
    repeat (L + 2) tick();
    nvec++; if (obs_q.size() !== exp_q.size()) begin nerr++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].dat !== exp_q[i].dat) begin
        nerr++; $display("FAIL rand[%0d] got %h@%0d want %h@%0d", i, obs_q[i].dat, obs_q[i].cyc, exp_q[i].dat, exp_q[i].cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear;
    issue_write(4'd5, 32'h55, 4'hF);
    issue_read(4'd4);
    clear = 1'b1;
    issue_read(4'd5);
    idle();
    model_zero();
    for (int i = 1; i <= DEPTH; i++) begin
      clear = (i == 5);
      tick();
      nvec++;
      if (req_ready !== (i == DEPTH)) begin
        nerr++; $display("FAIL clear_sweep_ready cycle %0d got %b want %b", i, req_ready, i == DEPTH);
      end
    end
    clear = 1'b0;
    issue_read(4'd5);
    idle();
    repeat (L + 2) tick();
    nvec++; if (obs_q.size() !== 3) begin nerr++; $display("FAIL clear_count got %0d want 3", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].dat !== exp_q[i].dat) begin
        nerr++; $display("FAIL clear_rsp[%0d] got %h@%0d want %h@%0d", i, obs_q[i].dat, obs_q[i].cyc, exp_q[i].dat, exp_q[i].cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midsweep;
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (7) tick();
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL midsweep_ready got %b want 0", req_ready); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      nvec++;
      if (init_done !== (i == DEPTH)) begin
        nerr++; $display("FAIL midsweep_init_done cycle %0d got %b want %b", i, init_done, i == DEPTH);
      end
    end
    model_zero();
    issue_read(4'd9);
    idle();
    repeat (L + 2) tick();
    nvec++; if (obs_q.size() !== 1) begin nerr++; $display("FAIL midsweep_count got %0d want 1", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].dat !== exp_q[i].dat) begin
        nerr++; $display("FAIL midsweep_rsp got %h@%0d want %h@%0d", obs_q[i].dat, obs_q[i].cyc, exp_q[i].dat, exp_q[i].cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    idle();
    test_reset();
    test_byte_enable();
    test_be_zero();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
